// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/port types and parameter limits for the fetch/data memory arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, RESP} arbState_t;
  typedef enum logic {PORT_FETCH = 1'b0, PORT_DATA = 1'b1} portId_t;
  localparam int ACCESS_CYCLES_MIN = 1;
  localparam int ACCESS_CYCLES_MAX = 4;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between an instruction-fetch port and a load/store data port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int FETCH_AW = 12
) (
  input  logic                i_clk,
  input  logic                i_nReset,
  input  logic                i_fetchReq,
  input  logic [FETCH_AW-1:0] i_fetchAddr,
  input  logic                i_fetchImm,
  output logic                o_fetchAck,
  output logic [7:0]          o_fetchData,
  input  logic                i_dataReq,
  input  logic                i_dataWe,
  input  logic [15:0]         i_dataAddr,
  input  logic [15:0]         i_dataWData,
  output logic                o_dataAck,
  output logic [15:0]         o_dataRData,
  output logic [15:0]         o_address,
  output logic                o_addressEn,
  output logic [15:0]         o_writeData,
  output logic                o_writeEn,
  output logic                o_readDataSelect,
  output logic                o_immediateSelect,
  output logic                o_outEnable,
  input  logic [15:0]         i_readData,
  output logic                o_busy
);
  localparam logic [1:0] WAIT_LOAD = 2'(ACCESS_CYCLES - 1);
  arbState_t state;
  portId_t curPort, lastServed, winner;
  logic curWe, curImm, fetchPend, dataPend, grant, lastAccess, isStore, inAccess;
  logic [15:0] curAddr, curWData;
  logic [1:0] waitCnt;
  // In RESP the port being acked still holds its request, so it is masked from re-arbitration.
  assign fetchPend = i_fetchReq && !(state == RESP && curPort == PORT_FETCH);
  assign dataPend = i_dataReq && !(state == RESP && curPort == PORT_DATA);
  assign grant = (state == IDLE || state == RESP) && (fetchPend || dataPend);
  assign winner = (fetchPend && dataPend) ? (lastServed == PORT_FETCH ? PORT_DATA : PORT_FETCH)
                                          : (dataPend ? PORT_DATA : PORT_FETCH);
  assign lastAccess = state == ACCESS && waitCnt == 2'd0;
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      state <= IDLE;
      curPort <= PORT_FETCH;
      lastServed <= PORT_FETCH;
      curWe <= 1'b0;
      curImm <= 1'b0;
      curAddr <= 16'h0;
      curWData <= 16'h0;
      waitCnt <= 2'd0;
      o_fetchData <= 8'h0;
      o_dataRData <= 16'h0;
    end else begin
      if (grant) begin
        curPort <= winner;
        lastServed <= winner;
        curWe <= winner == PORT_DATA && i_dataWe;
        curImm <= winner == PORT_FETCH && i_fetchImm;
        curAddr <= winner == PORT_DATA ? i_dataAddr : 16'(i_fetchAddr);
        curWData <= i_dataWData;
      end
      if (state == ADDR) waitCnt <= WAIT_LOAD;
      else if (state == ACCESS && waitCnt != 2'd0) waitCnt <= waitCnt - 2'd1;
      if (lastAccess && curPort == PORT_FETCH) o_fetchData <= i_readData[7:0];
      if (lastAccess && curPort == PORT_DATA && !curWe) o_dataRData <= i_readData;
      state <= grant ? ADDR : state == ADDR ? ACCESS : state == ACCESS ? (lastAccess ? RESP : ACCESS) : IDLE;
    end
  end
  assign isStore = curPort == PORT_DATA && curWe;
  assign inAccess = state == ACCESS;
  assign o_busy = state != IDLE;
  assign o_addressEn = state == ADDR;
  assign o_address = o_addressEn ? curAddr : 16'h0;
  assign o_writeEn = inAccess && isStore;
  assign o_writeData = o_writeEn ? curWData : 16'h0;
  assign o_outEnable = inAccess && !isStore;
  assign o_readDataSelect = inAccess && curPort == PORT_FETCH;
  assign o_immediateSelect = o_readDataSelect && curImm;
  assign o_fetchAck = state == RESP && curPort == PORT_FETCH;
  assign o_dataAck = state == RESP && curPort == PORT_DATA;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic against a transaction-level arbitration/memory model.
module tb_mem_arbiter;
  localparam int AC = 2;
  localparam int SLOT = AC + 2;
  logic i_clk = 1'b0, i_nReset = 1'b1;
  logic i_fetchReq = 1'b0, i_fetchImm = 1'b0, i_dataReq = 1'b0, i_dataWe = 1'b0;
  logic [11:0] i_fetchAddr = 12'h0;
  logic [15:0] i_dataAddr = 16'h0, i_dataWData = 16'h0, i_readData;
  logic o_fetchAck, o_dataAck, o_addressEn, o_writeEn, o_readDataSelect, o_immediateSelect, o_outEnable, o_busy;
  logic [7:0] o_fetchData;
  logic [15:0] o_dataRData, o_address, o_writeData;
  int total = 0, bad = 0;
  typedef struct {
    logic isData;
    logic we;
    logic imm;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;
  txn_t q[$];
  logic [15:0] ram[256], refRam[256], rom[512];
  logic [15:0] memAddr = 16'h0;
  logic lastData = 1'b0;
  logic [15:0] lastLoad = 16'h0;
  logic [7:0] lastFetch = 8'h0;

  mem_arbiter #(.ACCESS_CYCLES(AC), .FETCH_AW(12)) dut (
    .i_clk(i_clk), .i_nReset(i_nReset),
    .i_fetchReq(i_fetchReq), .i_fetchAddr(i_fetchAddr), .i_fetchImm(i_fetchImm),
    .o_fetchAck(o_fetchAck), .o_fetchData(o_fetchData),
    .i_dataReq(i_dataReq), .i_dataWe(i_dataWe), .i_dataAddr(i_dataAddr), .i_dataWData(i_dataWData),
    .o_dataAck(o_dataAck), .o_dataRData(o_dataRData),
    .o_address(o_address), .o_addressEn(o_addressEn), .o_writeData(o_writeData), .o_writeEn(o_writeEn),
    .o_readDataSelect(o_readDataSelect), .o_immediateSelect(o_immediateSelect), .o_outEnable(o_outEnable),
    .i_readData(i_readData), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural memory: address latched on the address strobe, RAM or ROM selected by o_readDataSelect.
  always @(posedge i_clk) begin
    if (o_addressEn) memAddr <= o_address;
    if (o_writeEn) ram[memAddr[7:0]] <= o_writeData;
  end
  assign i_readData = o_readDataSelect ? rom[{o_immediateSelect, memAddr[7:0]}] : ram[memAddr[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mkFetch(input logic imm, input logic [11:0] a);
    txn_t t;
    t.isData = 1'b0; t.we = 1'b0; t.imm = imm; t.addr = 16'(a); t.wdata = 16'h0;
    return t;
  endfunction

  function automatic txn_t mkData(input logic we, input logic [15:0] a, input logic [15:0] d);
    txn_t t;
    t.isData = 1'b1; t.we = we; t.imm = 1'b0; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // Ack k of a chain arrives k*(ACCESS+2) cycles after the requests are raised.
  task automatic runQ(input bit scramble, input bit dropEarly);
    int cyc = 0, served = 0, aCnt = 0, oeCnt = 0, weCnt = 0;
    bit more, wasData;
    while (q.size() > 0 && cyc < 10 * SLOT) begin
      @(negedge i_clk);
      cyc++;
      chk("strobe_excl", {29'h0, o_addressEn & o_outEnable, o_addressEn & o_writeEn, o_outEnable & o_writeEn}, 0);
      if (cyc == 1 && dropEarly) begin
        i_dataReq = 1'b0;
        i_fetchReq = 1'b0;
      end
      if (cyc == 1 && scramble) begin
        if (q[0].isData) begin
          i_dataAddr = 16'($urandom); i_dataWData = 16'($urandom); i_dataWe = 1'($urandom);
        end else begin
          i_fetchAddr = 12'($urandom); i_fetchImm = 1'($urandom);
        end
      end
      if (o_addressEn) begin
        aCnt++;
        chk("address", o_address, q[0].addr);
      end
      if (o_outEnable) begin
        oeCnt++;
        chk("rd_select", o_readDataSelect, !q[0].isData);
        chk("imm_select", o_immediateSelect, !q[0].isData && q[0].imm);
      end
      if (o_writeEn) begin
        weCnt++;
        chk("write_data", o_writeData, q[0].wdata);
      end
      if (o_fetchAck || o_dataAck) begin
        served++;
        chk("ack_port", {o_fetchAck, o_dataAck}, q[0].isData ? 2'b01 : 2'b10);
        chk("ack_cycle", cyc, served * SLOT);
        chk("addr_en_cycles", aCnt, 1);
        chk("oe_cycles", oeCnt, (q[0].isData && q[0].we) ? 0 : AC);
        chk("we_cycles", weCnt, (q[0].isData && q[0].we) ? AC : 0);
        if (q[0].isData && !q[0].we) lastLoad = refRam[q[0].addr[7:0]];
        if (!q[0].isData) lastFetch = rom[{q[0].imm, q[0].addr[7:0]}][7:0];
        if (q[0].isData && q[0].we) refRam[q[0].addr[7:0]] = q[0].wdata;
        chk("load_data", o_dataRData, lastLoad);
        chk("fetch_data", o_fetchData, lastFetch);
        aCnt = 0; oeCnt = 0; weCnt = 0;
        wasData = q[0].isData;
        q.delete(0);
        more = 0;
        foreach (q[i]) if (q[i].isData == wasData) more = 1;
        if (!more) begin
          if (wasData) i_dataReq = 1'b0;
          else i_fetchReq = 1'b0;
        end
      end
    end
    if (q.size() > 0) begin
      chk("ack_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge i_clk);
    chk("idle_after", {o_busy, o_fetchAck, o_dataAck}, 0);
  endtask

  task automatic issue(input bit doF, input bit doD, input logic fImm, input logic [11:0] fAddr,
                       input logic dWe, input logic [15:0] dAddr, input logic [15:0] dData,
                       input bit scramble, input bit dropEarly);
    txn_t f, d;
    f = mkFetch(fImm, fAddr);
    d = mkData(dWe, dAddr, dData);
    if (doF && doD) begin
      if (lastData) begin q.push_back(f); q.push_back(d); end
      else begin q.push_back(d); q.push_back(f); end
    end else if (doF) q.push_back(f);
    else q.push_back(d);
    lastData = q[q.size() - 1].isData;
    i_fetchImm = fImm; i_fetchAddr = fAddr;
    i_dataWe = dWe; i_dataAddr = dAddr; i_dataWData = dData;
    i_fetchReq = doF; i_dataReq = doD;
    runQ(scramble, dropEarly);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = 16'($urandom); refRam[i] = ram[i]; end
    for (int i = 0; i < 512; i++) rom[i] = 16'($urandom);
    ram[8'h34] = 16'hBEEF; refRam[8'h34] = 16'hBEEF;
    rom[{1'b1, 8'hFF}] = 16'h0042;
    #2 i_nReset = 1'b0;
    #1;
    chk("reset_strobes", {o_addressEn, o_outEnable, o_writeEn, o_readDataSelect, o_immediateSelect, o_busy}, 0);
    chk("reset_acks", {o_fetchAck, o_dataAck}, 0);
    chk("reset_buses", {o_address, o_writeData, o_dataRData}, 0);
    chk("reset_fetch_data", o_fetchData, 0);
    repeat (2) @(negedge i_clk);
    i_nReset = 1'b1;
    @(negedge i_clk);
    issue(0, 1, 0, 12'h0, 0, 16'h1234, 16'h0, 0, 0);
    chk("load_beef", o_dataRData, 16'hBEEF);
    issue(0, 1, 0, 12'h0, 1, 16'h0010, 16'hA5A5, 0, 0);
    chk("store_a5a5", ram[8'h10], 16'hA5A5);
    issue(1, 0, 1, 12'h0FF, 0, 16'h0, 16'h0, 0, 0);
    chk("fetch_42", o_fetchData, 8'h42);
    // Both requests held across three grants: data, fetch, data back to back.
    q.push_back(mkData(0, 16'h0010, 16'h0));
    q.push_back(mkFetch(1, 12'h0FF));
    q.push_back(mkData(0, 16'h0010, 16'h0));
    lastData = 1'b1;
    i_dataWe = 1'b0; i_dataAddr = 16'h0010; i_fetchImm = 1'b1; i_fetchAddr = 12'h0FF;
    i_dataReq = 1'b1; i_fetchReq = 1'b1;
    runQ(0, 0);
    issue(0, 1, 0, 12'h0, 0, 16'h0077, 16'h0, 0, 1);
    // Reset in the middle of a store's access phase.
    i_dataWe = 1'b1; i_dataAddr = 16'h0020; i_dataWData = 16'h1111; i_dataReq = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("pre_reset_we", o_writeEn, 1);
    i_nReset = 1'b0;
    #1;
    chk("abort_strobes", {o_writeEn, o_outEnable, o_addressEn, o_busy}, 0);
    i_dataReq = 1'b0;
    repeat (2) begin
      @(negedge i_clk);
      chk("abort_no_ack", {o_fetchAck, o_dataAck, o_busy}, 0);
    end
    chk("abort_no_write", ram[8'h20], refRam[8'h20]);
    i_nReset = 1'b1;
    lastData = 1'b0;
    lastLoad = 16'h0;
    lastFetch = 8'h0;
    @(negedge i_clk);
    issue(1, 1, 0, 12'h012, 0, 16'h0034, 16'h0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      int mode;
      mode = int'($urandom_range(1, 3));
      issue(mode[0], mode[1], 1'($urandom), 12'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1, 0);
      if ($urandom_range(0, 1) == 1) @(negedge i_clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
